// File: rtl/audio_tone_mixer.sv
// audio_tone_mixer: NUM_TONES free-running square-wave oscillators summed into
// the codec sample stream with signed saturation. The block drives the
// Audio_Controller FIFO read/write handshake itself.
module audio_tone_mixer #(
    parameter int unsigned SAMPLE_W  = 32,
    parameter int unsigned NUM_TONES = 4,
    parameter int unsigned PERIOD_W  = 19,
    parameter int unsigned AMP_W     = 16
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [NUM_TONES-1:0]          tone_en,
    input  logic [NUM_TONES*PERIOD_W-1:0] tone_half_period,
    input  logic [NUM_TONES*AMP_W-1:0]    tone_amp,
    input  logic                          passthru_en,
    input  logic                          audio_in_available,
    input  logic [SAMPLE_W-1:0]           left_channel_audio_in,
    input  logic [SAMPLE_W-1:0]           right_channel_audio_in,
    input  logic                          audio_out_allowed,
    output logic                          read_audio_in,
    output logic                          write_audio_out,
    output logic [SAMPLE_W-1:0]           left_channel_audio_out,
    output logic [SAMPLE_W-1:0]           right_channel_audio_out,
    output logic [15:0]                   sat_count
);

    localparam int unsigned ACC_W = SAMPLE_W + 4;
    localparam int unsigned CON_W = AMP_W + 1;
    localparam int unsigned IDX_W = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    state_e                              state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic signed [ACC_W-1:0]             acc_l_q, acc_l_d;
    logic signed [ACC_W-1:0]             acc_r_q, acc_r_d;
    logic                                read_q, read_d;
    logic                                write_q, write_d;
    logic [SAMPLE_W-1:0]                 out_l_q, out_l_d;
    logic [SAMPLE_W-1:0]                 out_r_q, out_r_d;
    logic [15:0]                         sat_cnt_q, sat_cnt_d;
    logic [NUM_TONES-1:0][PERIOD_W-1:0]  cnt_q, cnt_d;
    logic [NUM_TONES-1:0]                phase_q, phase_d;

    logic [NUM_TONES-1:0][ACC_W-1:0]     contrib;
    logic signed [CON_W-1:0]             amp_ext;
    logic signed [ACC_W-1:0]             tone_sel;
    logic signed [ACC_W-1:0]             fin_l, fin_r;
    logic [SAMPLE_W:0]                   sat_l, sat_r;

    // Clamp to SAMPLE_W signed; MSB of the result flags a clip.
    function automatic logic [SAMPLE_W:0] sat_f(input logic [ACC_W-1:0] v);
        logic [ACC_W-SAMPLE_W:0] top;
        top = v[ACC_W-1:SAMPLE_W-1];
        if ((top == '0) || (top == '1)) begin
            sat_f = {1'b0, v[SAMPLE_W-1:0]};
        end else if (v[ACC_W-1]) begin
            sat_f = {1'b1, 1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            sat_f = {1'b1, 1'b0, {(SAMPLE_W-1){1'b1}}};
        end
    endfunction

    // Oscillator counters and phases; >= compare so a shrunk period wraps at once.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        for (int k = 0; k < int'(NUM_TONES); k++) begin
            if (!tone_en[k]) begin
                cnt_d[k]   = '0;
                phase_d[k] = 1'b1;
            end else if (cnt_q[k] >= tone_half_period[k*PERIOD_W +: PERIOD_W]) begin
                cnt_d[k]   = '0;
                phase_d[k] = ~phase_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + PERIOD_W'(1);
            end
        end
    end

    // Signed per-tone contribution from the current phase and live amplitude.
    always_comb begin
        contrib = '0;
        amp_ext = '0;
        for (int k = 0; k < int'(NUM_TONES); k++) begin
            amp_ext = signed'({1'b0, tone_amp[k*AMP_W +: AMP_W]});
            if (tone_en[k]) begin
                contrib[k] = phase_q[k] ? ACC_W'(amp_ext) : ACC_W'(-amp_ext);
            end
        end
    end

    // The last tone is folded into the final sum so a free output slot is
    // written on the same edge; WRITE only holds the sum under backpressure.
    assign tone_sel = $signed(contrib[idx_q]);
    assign fin_l    = (state_q == S_ACCUM) ? acc_l_q + tone_sel : acc_l_q;
    assign fin_r    = (state_q == S_ACCUM) ? acc_r_q + tone_sel : acc_r_q;
    assign sat_l    = sat_f(fin_l);
    assign sat_r    = sat_f(fin_r);

    // Capture / accumulate / write sequencing.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        read_d    = 1'b0;
        write_d   = 1'b0;
        out_l_d   = out_l_q;
        out_r_d   = out_r_q;
        sat_cnt_d = sat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (audio_in_available && audio_out_allowed) begin
                    acc_l_d = passthru_en ? ACC_W'($signed(left_channel_audio_in))  : '0;
                    acc_r_d = passthru_en ? ACC_W'($signed(right_channel_audio_in)) : '0;
                    idx_d   = '0;
                    read_d  = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (idx_q == IDX_W'(NUM_TONES - 1)) begin
                    if (audio_out_allowed) begin
                        out_l_d = sat_l[SAMPLE_W-1:0];
                        out_r_d = sat_r[SAMPLE_W-1:0];
                        write_d = 1'b1;
                        if ((sat_l[SAMPLE_W] || sat_r[SAMPLE_W]) && (sat_cnt_q != 16'hFFFF)) begin
                            sat_cnt_d = sat_cnt_q + 16'd1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        acc_l_d = fin_l;
                        acc_r_d = fin_r;
                        state_d = S_WRITE;
                    end
                end else begin
                    acc_l_d = fin_l;
                    acc_r_d = fin_r;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            S_WRITE: begin
                if (audio_out_allowed) begin
                    out_l_d = sat_l[SAMPLE_W-1:0];
                    out_r_d = sat_r[SAMPLE_W-1:0];
                    write_d = 1'b1;
                    if ((sat_l[SAMPLE_W] || sat_r[SAMPLE_W]) && (sat_cnt_q != 16'hFFFF)) begin
                        sat_cnt_d = sat_cnt_q + 16'd1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and oscillator registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            sat_cnt_q <= '0;
            cnt_q     <= '0;
            phase_q   <= '1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            read_q    <= read_d;
            write_q   <= write_d;
            out_l_q   <= out_l_d;
            out_r_q   <= out_r_d;
            sat_cnt_q <= sat_cnt_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign read_audio_in           = read_q;
    assign write_audio_out         = write_q;
    assign left_channel_audio_out  = out_l_q;
    assign right_channel_audio_out = out_r_q;
    assign sat_count               = sat_cnt_q;

endmodule

// File: doc/audio_tone_mixer.md
Name: audio_tone_mixer

Overview:
Parametrised successor to the single square-wave tone injector in the audio example top level. It runs NUM_TONES independent square-wave oscillators, each with its own enable, half-period and amplitude. The tone sum is mixed into the codec input stream (optional passthrough) with signed saturation, and the block drives the Audio_Controller read/write handshake itself. It sits between Audio_Controller's input FIFO outputs and its output FIFO inputs.

Parameters:
SAMPLE_W, 32, signed sample width of the audio in/out buses
NUM_TONES, 4, number of oscillators (1..8)
PERIOD_W, 19, width of each half-period field
AMP_W, 16, width of each unsigned amplitude field

Ports:
CLOCK_50  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
tone_en  in  NUM_TONES  per-oscillator enable
tone_half_period  in  NUM_TONES*PERIOD_W  field k = half-period minus 1, in clocks
tone_amp  in  NUM_TONES*AMP_W  field k = unsigned amplitude
passthru_en  in  1  1: add codec input to mix; 0: tones only
audio_in_available  in  1  from Audio_Controller
left_channel_audio_in  in  SAMPLE_W  signed input sample
right_channel_audio_in  in  SAMPLE_W  signed input sample
audio_out_allowed  in  1  from Audio_Controller
read_audio_in  out  1  one-cycle pop pulse to the input FIFO
write_audio_out  out  1  one-cycle push pulse to the output FIFO
left_channel_audio_out  out  SAMPLE_W  signed mixed sample (registered)
right_channel_audio_out  out  SAMPLE_W  signed mixed sample (registered)
sat_count  out  16  number of samples clipped on either channel, saturating

Behaviour:
- Reset: state IDLE; all outputs 0; oscillator counters 0; phases 1 (high); accumulators 0.
- Oscillator k (free-running, independent of the FSM):
  - If tone_en[k]=0: counter held at 0, phase held at 1.
  - Otherwise the counter increments each clock. When counter >= half_period[k], counter <= 0 and phase toggles. The compare is >=, not ==, so shrinking the period below the current count wraps on the next clock.
  - Contribution = +amp[k] when phase=1, -amp[k] when phase=0, and 0 when disabled. Amplitude is zero-extended to AMP_W+1 bits before negation.
- Accumulators: SAMPLE_W+4 bits signed, one per channel.
- FSM:
  - IDLE: when audio_in_available & audio_out_allowed, load both accumulators with the sign-extended inputs (0 if passthru_en=0), set tone index 0, go to ACCUM. read_audio_in is registered: high for exactly the one cycle after capture.
  - ACCUM: for NUM_TONES cycles, tone k's contribution is added to both accumulators (same value on both channels). Oscillator phase is sampled in that cycle. After the last tone, go to WRITE.
  - WRITE: saturate each accumulator to SAMPLE_W signed (max 2^(SAMPLE_W-1)-1, min -2^(SAMPLE_W-1)).
    - If audio_out_allowed=1: register outputs, pulse write_audio_out for one cycle, increment sat_count (sticky at 0xFFFF) if either channel clipped, go to IDLE.
    - If audio_out_allowed=0: hold in WRITE with no pulse until it rises.
- Latency: capture at cycle C; read pulse at C+1; earliest write pulse at C+NUM_TONES+1. Outputs change only on a write pulse and hold otherwise.
- No new capture while in ACCUM or WRITE. audio_in_available during those states is ignored; the sample stays in the FIFO.
- At most one read pulse and one write pulse per sample. The two pulses never occur in the same cycle for NUM_TONES>=1.
- Tone parameter changes mid-ACCUM take effect at the tone currently being indexed.
- Reset asserted mid-operation: immediate return to reset values; the in-flight sample is discarded and no write pulse is emitted.

Test Plan:
- Passthrough, all tones disabled, passthru_en=1, inputs L=1234, R=-5 with available and allowed high → read pulse at C+1; write pulse at C+5 (NUM_TONES=4) with L=1234, R=-5; sat_count=0.
- tone_en=0001, half_period0=3, amp0=1000, passthru_en=0 → phase0 toggles every 4 clocks; every output sample is L=R=+1000 or -1000, matching the phase in tone-0's ACCUM cycle.
- Saturation: L_in=0x7FFFFFF0, all four tones amp=0xFFFF phase high → L_out=0x7FFFFFFF, sat_count=1. L_in=0x80000010 with all phases low → 0x80000000, sat_count=2.
- Backpressure: drop audio_out_allowed right after capture, hold 20 cycles → FSM stays in WRITE, no write pulse, no second read pulse; raise it → exactly one write pulse the next cycle.
- Period shrink: half_period0 changed 100→5 while counter=50 → phase toggles on the next clock, then every 6 clocks.
- Reset pulsed during ACCUM → all outputs 0 within the cycle; no write pulse; the next available sample is processed with normal latency.
